i2c_master_core: RTL
====================

# i2c_master_core

Single-master I2C bus controller that generates START, STOP, byte-write and byte-read bus sequences from a simple command/response interface. It sits directly upstream of the I2C slave cores on the shared open-drain `sda`/`scl` pair and is the bus agent that feeds them. It supports clock stretching by slaves. It does not implement multi-master arbitration.

## Interface
Parameters:
- `CLK_DIV`, default 125: clk cycles per SCL quarter-period; SCL = clk/(4·CLK_DIV) unstretched. Legal range 4..65535; counter width 16 bits.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  0=START (incl. repeated), 1=STOP, 2=WRITE, 3=READ
- `cmd_data`  in  8  byte to transmit (WRITE only)
- `cmd_ack`  in  1  READ only: ack bit to drive in the 9th bit (0=ACK, 1=NACK)
- `rsp_valid`  out  1  one-cycle pulse on command completion
- `rsp_data`  out  8  byte received (READ); 0 otherwise
- `rsp_nack`  out  1  WRITE: sampled slave ack bit; READ: echo of `cmd_ack`; START/STOP: 0; illegal command: 1
- `bus_owned`  out  1  high from completion of START until completion of STOP
- `sda`  inout  1  open-drain: drives 0 or z only
- `scl`  inout  1  open-drain: drives 0 or z only

## Operation
- Inputs `sda` and `scl` pass through a 2-flop synchronizer (`sda_s`, `scl_s`). Only synchronized values are used.
- FSM states: IDLE, START, STOP, WRITE, READ, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch `cmd_op`/`cmd_data`/`cmd_ack`, drop `cmd_ready`, and enter the op state.
  - `cmd_valid` while `cmd_ready`=0 is ignored.
- Illegal command: WRITE, READ or STOP while `bus_owned`=0. Go to DONE immediately with no bus activity and `rsp_nack`=1.
- Every op is built from quarters Q0..Q3:
  - Q0, Q2 and Q3 each last CLK_DIV cycles.
  - Q1 releases SCL and counts only cycles with `scl_s`=1, so it lasts CLK_DIV cycles after SCL is seen high. This gives slave clock stretching and synchronizer latency.
- START (4 quarters):
  - Q0: release SDA, keep SCL as is.
  - Q1: release SCL.
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - On completion, `bus_owned`=1.
- STOP (4 quarters):
  - Q0: pull SDA low (SCL low).
  - Q1: release SCL.
  - Q2: release SDA.
  - Q3: idle, providing bus-free time.
  - On completion, `bus_owned`=0.
- WRITE: 9 bits × 4 quarters.
  - Bits 1–8: in Q0 drive SDA = `cmd_data[7..0]`, MSB first (0 → pull low, 1 → release).
  - Bit 9: SDA released.
  - Q1 releases SCL and Q3 pulls SCL low.
  - `sda_s` is sampled on the last cycle of Q2 of bit 9 → `rsp_nack`.
- READ: 9 bits.
  - Bits 1–8: SDA released; `sda_s` sampled on the last cycle of Q2 and shifted in MSB first → `rsp_data`.
  - Bit 9: drive `cmd_ack` in Q0.
- SDA changes only in Q0 (SCL low), except START Q2 and STOP Q2.
- After any WRITE/READ/START the block holds SCL low.
- DONE (1 cycle): pulse `rsp_valid`, update `rsp_data`/`rsp_nack`, go to IDLE.
  - `cmd_ready` is 1 from the cycle after `rsp_valid`.
  - `rsp_data`/`rsp_nack` hold until the next completion.
- A ST
ART while `bus_owned`=1 is a repeated start. SCL is low on entry, so Q0 releases SDA while SCL is low.

## Timing
- Reset values: `sda`=z, `scl`=z, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_nack`=0, `bus_owned`=0.
- Reset is asynchronous and releases both lines immediately. A reset mid-transfer abandons the op with no STOP generated.
- Quarter counting starts on the cycle after accept.
- Q1 unstretched length:
  - CLK_DIV+2 cycles when SCL was low on entry (synchronizer delay).
  - CLK_DIV cycles when SCL was already high (START from idle).
- Latency from the accept edge to the `rsp_valid` cycle, unstretched:
  - START from idle: 4·CLK_DIV+1.
  - Repeated START or STOP: 4·CLK_DIV+3.
  - WRITE or READ: 9·(4·CLK_DIV+2)+1.
  - Illegal command: 1.
- Stretch: every cycle a slave holds SCL low in Q1 adds one cycle to that op.
- `rsp_valid` is high for exactly 1 cycle per accepted command.

## Test plan
- Reset, then CLK_DIV=4, START then STOP:
  - `rsp_valid` after 17 and 19 cycles.
  - `bus_owned` goes 1 then 0.
  - A slave monitor sees one start_det and one stop_det.
- With an I2C slave core at address 0x50:
  - START, WRITE 0xA0 → `rsp_nack`=0.
  - WRITE 0x3C → `rsp_nack`=0; slave `rx_data`=0x3C with `data_valid`.
  - STOP.
- START, WRITE 0xA2 (address 0x51) → `rsp_nack`=1. Slave never drives SDA.
- Slave `tx_data`=0x5A: START, WRITE 0xA1, READ with `cmd_ack`=1 → `rsp_data`=0x5A, `rsp_nack`=1; then STOP.
- Clock stretch: the bench holds SCL low for 50 cycles in Q1 of bit 3 of a WRITE → latency grows by exactly 50 and data is intact.
- Illegal command and mid-transfer reset:
  - WRITE with `bus_owned`=0 → `rsp_valid` after 1 cycle with `rsp_nack`=1; `sda`/`scl` never driven.
  - Assert `rst_n` mid-WRITE → both lines z at once; all outputs at reset values.

Source files
------------

// File: rtl/i2c_master_core.sv
// Single-master I2C bus controller.
// Turns START / STOP / WRITE / READ commands into open-drain bus sequences
// and reports each completion with a one-cycle response pulse. Every bus bit
// is built from four quarters of CLK_DIV cycles. The SCL-high quarter (Q1)
// only counts cycles in which SCL is seen high, so slave clock stretching and
// synchronizer latency are absorbed automatically.
module i2c_master_core #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       bus_owned,
    inout  wire        sda,
    inout  wire        scl
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_STOP  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0]  OP_START = 2'd0;
    localparam logic [1:0]  OP_STOP  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;
    localparam logic [1:0]  OP_READ  = 2'd3;

    localparam logic [1:0]  Q0 = 2'd0;
    localparam logic [1:0]  Q1 = 2'd1;
    localparam logic [1:0]  Q2 = 2'd2;
    localparam logic [1:0]  Q3 = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  BIT_ACK  = 4'd8;
    localparam logic [3:0]  BIT_LAST_DATA = 4'd7;

    state_e      state_q;
    logic [1:0]  qtr_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [1:0]  op_q;
    logic [7:0]  data_q;
    logic        ack_q;
    logic        nack_q;
    logic        illegal_q;
    logic        sda_oe_q;
    logic        scl_oe_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_nack_q;
    logic        bus_owned_q;
    logic [1:0]  sda_sync_q;
    logic [1:0]  scl_sync_q;

    logic        sda_s;
    logic        scl_s;
    logic        qtr_tick_s;
    logic        qtr_end_s;
    logic        illegal_s;

    // Open-drain pads: only ever pull low or release.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;
    assign scl = scl_oe_q ? 1'b0 : 1'bz;

    assign sda_s = sda_sync_q[1];
    assign scl_s = scl_sync_q[1];

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign bus_owned = bus_owned_q;

    // Bus-touching commands are refused unless a START has claimed the bus.
    assign illegal_s = (cmd_op != OP_START) && !bus_owned_q;

    // Two-flop synchronizers; idle bus lines read as high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync_q <= 2'b11;
            scl_sync_q <= 2'b11;
        end else begin
            sda_sync_q <= {sda_sync_q[0], sda};
            scl_sync_q <= {scl_sync_q[0], scl};
        end
    end

    // Quarter pacing: Q1 advances only while SCL is observed high.
    always_comb begin
        qtr_tick_s = 1'b1;
        if (qtr_q == Q1) begin
            qtr_tick_s = scl_s;
        end else begin
            qtr_tick_s = 1'b1;
        end
        qtr_end_s = qtr_tick_s && (cnt_q == CNT_LAST);
    end

    // Command FSM with registered pad enables and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            qtr_q       <= Q0;
            cnt_q       <= 16'd0;
            bit_q       <= 4'd0;
            op_q        <= OP_START;
            data_q      <= 8'd0;
            ack_q       <= 1'b0;
            nack_q      <= 1'b0;
            illegal_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            scl_oe_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_nack_q  <= 1'b0;
            bus_owned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (!cmd_ready_q) begin
                        // Re-open the command port the cycle after the response.
                        cmd_ready_q <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        ack_q       <= cmd_ack;
                        cnt_q       <= 16'd0;
                        qtr_q       <= Q0;
                        bit_q       <= 4'd0;
                        nack_q      <= 1'b0;
                        illegal_q   <= illegal_s;
                        if (illegal_s) begin
                            state_q <= ST_DONE;
                        end else begin
                            // Q0 of the first bit starts now: set SDA for it.
                            case (cmd_op)
                                OP_START: begin
                                    state_q  <= ST_START;
                                    sda_oe_q <= 1'b0;
                                end
                                OP_STOP: begin
                                    state_q  <= ST_STOP;
                                    sda_oe_q <= 1'b1;
                                end
                                OP_WRITE: begin
                                    state_q  <= ST_WRITE;
                                    sda_oe_q <= ~cmd_data[7];
                                end
                                OP_READ: begin
                                    state_q  <= ST_READ;
                                    sda_oe_q <= 1'b0;
                                end
                                default: begin
                                    state_q <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                end

                ST_START, ST_STOP, ST_WRITE, ST_READ: begin
                    if (qtr_end_s) begin
                        cnt_q <= 16'd0;
                        qtr_q <= qtr_q + 2'd1;
                        // Actions take effect on entry to the following quarter.
                        case (qtr_q)
                            Q0: begin
                                scl_oe_q <= 1'b0;
                            end
                            Q1: begin
                                if (state_q == ST_START) begin
                                    sda_oe_q <= 1'b1;
                                end else if (state_q == ST_STOP) begin
                                    sda_oe_q <= 1'b0;
                                end
                            end
                            Q2: begin
                                // STOP leaves SCL released through its bus-free quarter.
                                if (state_q != ST_STOP) begin
                                    scl_oe_q <= 1'b1;
                                end
                                if ((state_q == ST_WRITE) && (bit_q == BIT_ACK)) begin
                                    nack_q <= sda_s;
                                end
                                if ((state_q == ST_READ) && (bit_q != BIT_ACK)) begin
                                    data_q <= {data_q[6:0], sda_s};
                                end
                            end
                            Q3: begin
                                if ((state_q == ST_START) || (state_q == ST_STOP) ||
                                    (bit_q == BIT_ACK)) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    bit_q <= bit_q + 4'd1;
                                    if (state_q == ST_WRITE) begin
                                        data_q   <= {data_q[6:0], 1'b0};
                                        sda_oe_q <= (bit_q == BIT_LAST_DATA) ? 1'b0 : ~data_q[6];
                                    end else begin
                                        sda_oe_q <= (bit_q == BIT_LAST_DATA) ? ~ack_q : 1'b0;
                                    end
                                end
                            end
                            default: begin
                                qtr_q <= Q0;
                            end
                        endcase
                    end else if (qtr_tick_s) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_DONE: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                    if (illegal_q) begin
                        rsp_data_q <= 8'd0;
                        rsp_nack_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_START: begin
                                rsp_data_q  <= 8'd0;
                                rsp_nack_q  <= 1'b0;
                                bus_owned_q <= 1'b1;
                            end
                            OP_STOP: begin
                                rsp_data_q  <= 8'd0;
                                rsp_nack_q  <= 1'b0;
                                bus_owned_q <= 1'b0;
                            end
                            OP_WRITE: begin
                                rsp_data_q <= 8'd0;
                                rsp_nack_q <= nack_q;
                            end
                            OP_READ: begin
                                rsp_data_q <= data_q;
                                rsp_nack_q <= ack_q;
                            end
                            default: begin
                                rsp_data_q <= 8'd0;
                                rsp_nack_q <= 1'b1;
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
